// File: rtl/lx32_branch_unit.sv
// LX32 branch resolution unit: evaluates the branch condition, registers the
// resolved result, and issues a one-cycle redirect plus wrong-path drain on a mispredict.
module lx32_branch_unit #(
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic        in_pred_taken,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_taken,
   output logic        out_illegal,
   output logic [31:0] out_pc,
   output logic [31:0] out_next_pc,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] mispredict_count
);

   typedef enum logic {
      RUN,
      DRAIN
   } state_t;

   localparam logic [2:0] OP_EQ  = 3'd0;
   localparam logic [2:0] OP_NE  = 3'd1;
   localparam logic [2:0] OP_LT  = 3'd2;
   localparam logic [2:0] OP_GE  = 3'd3;
   localparam logic [2:0] OP_LTU = 3'd4;
   localparam logic [2:0] OP_GEU = 3'd5;

   state_t      state_q, state_d;
   logic [3:0]  drain_q, drain_d;

   logic        cond_taken;
   logic        illegal;
   logic [31:0] next_pc;
   logic        mispredict;
   logic        take;

   always_comb begin
      cond_taken = 1'b0;
      illegal    = 1'b0;
      unique case (in_op)
         OP_EQ:   cond_taken = (in_rs1 == in_rs2);
         OP_NE:   cond_taken = (in_rs1 != in_rs2);
         OP_LT:   cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
         OP_GE:   cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
         OP_LTU:  cond_taken = (in_rs1 <  in_rs2);
         OP_GEU:  cond_taken = (in_rs1 >= in_rs2);
         default: illegal    = 1'b1;
      endcase
   end

   assign next_pc    = cond_taken ? (in_pc + in_imm) : (in_pc + 32'd4);
   assign mispredict = !illegal && (cond_taken != in_pred_taken);

   // DRAIN swallows wrong-path input, so it is always ready regardless of the output stage.
   assign in_ready = rst_n && ((state_q == DRAIN) || !out_valid || out_ready);
   assign take     = in_valid && in_ready && (state_q == RUN);

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         RUN: begin
            if (take && mispredict && (DRAIN_CYCLES != 0)) begin
               state_d = DRAIN;
               drain_d = 4'(DRAIN_CYCLES);
            end
         end
         DRAIN: begin
            drain_d = drain_q - 4'd1;
            if (drain_q <= 4'd1) begin
               state_d = RUN;
               drain_d = 4'd0;
            end
         end
         default: begin
            state_d = RUN;
            drain_d = 4'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= RUN;
         drain_q          <= 4'd0;
         out_valid        <= 1'b0;
         out_taken        <= 1'b0;
         out_illegal      <= 1'b0;
         out_pc           <= 32'd0;
         out_next_pc      <= 32'd0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= 32'd0;
         mispredict_count <= 32'd0;
      end else begin
         state_q        <= state_d;
         drain_q        <= drain_d;
         redirect_valid <= take && mispredict;

         if (take && mispredict) begin
            redirect_pc <= next_pc;
            if (mispredict_count != 32'hFFFF_FFFF)
               mispredict_count <= mispredict_count + 32'd1;
         end

         if (take) begin
            out_valid   <= 1'b1;
            out_taken   <= cond_taken;
            out_illegal <= illegal;
            out_pc      <= in_pc;
            out_next_pc <= next_pc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/lx32_branch_unit.md
LX32_BRANCH_UNIT -- requirements
Module: lx32_branch_unit

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, range 0..15: cycles of wrong-path input discarded after a mispredict.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  decode presents a branch.
REQ-005 in_ready  output  1  unit accepts the presented branch this cycle.
REQ-006 in_op  input  3  branch op: EQ=0, NE=1, LT=2, GE=3, LTU=4, GEU=5.
REQ-007 in_rs1, in_rs2  input  32 each  comparison operands.
REQ-008 in_pc, in_imm  input  32 each  branch PC and sign-extended offset.
REQ-009 in_pred_taken  input  1  fetch-stage prediction.
REQ-010 out_valid  output  1  resolved branch held in the output register.
REQ-011 out_ready  input  1  downstream consumes the output.
REQ-012 out_taken, out_illegal  output  1 each  resolved direction; op code 6 or 7 received.
REQ-013 out_pc, out_next_pc  output  32 each  branch PC; architecturally correct next PC.
REQ-014 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-015 redirect_pc  output  32  redirect target.
REQ-016 mispredict_count  output  32  saturating mispredict counter.

Function
REQ-017 Comparisons: EQ/NE use equality, LT/GE use signed 32-bit compare, LTU/GEU use unsigned compare.
REQ-018 Op codes 6 and 7 shall resolve not-taken with out_illegal=1 and shall never count as a mispredict.
REQ-019 Target = in_pc + in_imm modulo 2^32; fall-through = in_pc + 4 modulo 2^32.
REQ-020 next_pc = target when taken, otherwise fall-through.
REQ-021 Accept occurs when in_valid && in_ready.
REQ-022 FSM states are RUN and DRAIN.
REQ-023 In RUN, in_ready = !out_valid || out_ready.
REQ-024 In RUN, the result of an accepted branch is registered and appears on out_* exactly 1 cycle after accept.
REQ-025 out_* shall hold stable while out_valid=1 && out_ready=0.
REQ-026 If out_ready=1 and a new accept occur in the same cycle, the output register is replaced with the new result, with no bubble.
REQ-027 out_valid clears after a handshake when no new accept occurs that cycle.
REQ-028 Mispredict = legal op && (taken != in_pred_taken).
REQ-029 On a mispredict accept:
  - redirect_valid=1 and redirect_pc=next_pc for exactly the following cycle;
  - mispredict_count increments, holding at 0xFFFFFFFF;
  - the FSM enters DRAIN with drain counter = DRAIN_CYCLES.
REQ-030 With DRAIN_CYCLES=0, the FSM stays in RUN and only the redirect pulse and counter update occur.
REQ-031 In DRAIN:
  - in_ready=1 and inputs are discarded: no output, no redirect, no count;
  - the counter decrements every cycle, and the FSM returns to RUN in the cycle after it reaches 1.
REQ-032 In DRAIN, the output register continues to obey REQ-025 and REQ-027.
REQ-033 A correctly predicted branch produces no redirect and stays in RUN.

Reset
REQ-034 While rst_n=0 at a clock edge:
  - out_valid=0, redirect_valid=0, out_taken=0, out_illegal=0;
  - out_pc=0, out_next_pc=0, redirect_pc=0, mispredict_count=0;
  - FSM=RUN, drain counter=0.
REQ-035 Reset asserted mid-DRAIN or with an output pending shall discard all state, and no redirect shall fire afterwards.
REQ-036 in_ready=0 during reset; it is 1 in the first cycle after reset.

Verification
REQ-037 BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> 1 cycle later: out_taken=1, out_next_pc=0x120, redirect_valid=1 with redirect_pc=0x120, count=1.
REQ-038 BLTU with the same operands, pred=0 -> out_taken=0, out_next_pc=0x104, no redirect, count unchanged.
REQ-039 Mispredict followed by 3 back-to-back valid inputs with DRAIN_CYCLES=2 -> the first two inputs are discarded, and the third is accepted and output normally.
REQ-040 out_ready=0 for 4 cycles with in_valid=1 held -> in_ready=0 and out_* stable; on release, the new branch is accepted in the same cycle and appears next cycle (REQ-026).
REQ-041 op=7, pred=1 -> out_illegal=1, out_taken=0, next_pc=pc+4, no redirect.
REQ-042 Two further checks:
  - Preload count to saturation, then mispredict -> count stays 0xFFFFFFFF.
  - rst_n=0 during DRAIN -> all outputs zero; the next valid input is accepted the cycle after reset releases.
